// File: rtl/respondedor_memoria_if.sv
// Request/response bundle between the control unit and the memory responder.
interface respondedor_memoria_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic          Solicitud;
  logic          Escribir;
  logic [AW-1:0] Direccion;
  logic [DW-1:0] DatoEntrada;
  logic [DW-1:0] DatoSalida;
  logic          Listo;
  logic          Ocupado;
  logic          Error;

  modport master (
    output Solicitud, Escribir, Direccion, DatoEntrada,
    input  DatoSalida, Listo, Ocupado, Error
  );

  modport slave (
    input  Solicitud, Escribir, Direccion, DatoEntrada,
    output DatoSalida, Listo, Ocupado, Error
  );
endinterface

// File: rtl/respondedor_memoria.sv
// Word-store responder with fixed wait states and a four-phase Solicitud/Listo handshake.
// Define RESPONDEDOR_ERROR_RANGO_EN to flag and drop out-of-range accesses instead of wrapping.
module respondedor_memoria #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned PALABRAS = 256,
  parameter int unsigned ESPERAS  = 2
) (
  input  logic                 Reloj,
  input  logic                 Reiniciar,
  respondedor_memoria_if.slave mem_if
);
  localparam int unsigned IW = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
  localparam int unsigned CW = 4;
  localparam bit SIN_ESPERA  = (ESPERAS == 0);

  typedef enum logic [1:0] {REPOSO, ESPERA, LISTO} estado_e;

  estado_e        estado_q, estado_d;
  logic [CW-1:0]  cont_q, cont_d;
  logic           escribir_q, escribir_d;
  logic [AW-1:0]  dir_q, dir_d;
  logic [DW-1:0]  dato_q, dato_d;
  logic [DW-1:0]  salida_q, salida_d;
  logic           listo_q, listo_d;
  logic           ocupado_q, ocupado_d;
  logic           error_q, error_d;

  logic [DW-1:0]  mem_q [PALABRAS];

  logic           commit;
  logic           acc_esc;
  logic [AW-1:0]  acc_dir;
  logic [DW-1:0]  acc_dato;
  logic           fuera;
  logic [IW-1:0]  idx;
  logic           mem_we;

  // Next state, request latch and commit decode
  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    escribir_d = escribir_q;
    dir_d      = dir_q;
    dato_d     = dato_q;
    commit     = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        if (mem_if.Solicitud) begin
          escribir_d = mem_if.Escribir;
          dir_d      = mem_if.Direccion;
          dato_d     = mem_if.DatoEntrada;
          cont_d     = CW'(ESPERAS);
          if (SIN_ESPERA) begin
            estado_d = LISTO;
            commit   = 1'b1;
          end else begin
            estado_d = ESPERA;
          end
        end
      end
      ESPERA: begin
        if (!mem_if.Solicitud) begin
          estado_d = REPOSO;
          cont_d   = '0;
        end else if (cont_q == CW'(1)) begin
          estado_d = LISTO;
          cont_d   = '0;
          commit   = 1'b1;
        end else begin
          cont_d = cont_q - CW'(1);
        end
      end
      LISTO: begin
        if (!mem_if.Solicitud) estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  // With no wait states the commit edge is also the latch edge, so take the live inputs
  always_comb begin
    acc_esc  = (estado_q == REPOSO) ? mem_if.Escribir    : escribir_q;
    acc_dir  = (estado_q == REPOSO) ? mem_if.Direccion   : dir_q;
    acc_dato = (estado_q == REPOSO) ? mem_if.DatoEntrada : dato_q;
`ifdef RESPONDEDOR_ERROR_RANGO_EN
    fuera = (32'(acc_dir) >= PALABRAS);
    idx   = fuera ? '0 : IW'(acc_dir);
`else
    fuera = 1'b0;
    idx   = IW'(32'(acc_dir) % PALABRAS);
`endif
    mem_we    = commit && acc_esc && !fuera;
    salida_d  = salida_q;
    if (commit && !acc_esc && !fuera) salida_d = mem_q[idx];
    listo_d   = (estado_q == LISTO) && mem_if.Solicitud;
    ocupado_d = (estado_d != REPOSO);
    error_d   = (estado_d == LISTO) && (commit ? fuera : error_q);
  end

  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      estado_q   <= REPOSO;
      cont_q     <= '0;
      escribir_q <= 1'b0;
      dir_q      <= '0;
      dato_q     <= '0;
      salida_q   <= '0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      escribir_q <= escribir_d;
      dir_q      <= dir_d;
      dato_q     <= dato_d;
      salida_q   <= salida_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
      error_q    <= error_d;
    end
  end

  // Word store has no reset; contents survive Reiniciar
  always_ff @(posedge Reloj) begin
    if (mem_we) mem_q[idx] <= acc_dato;
  end

  assign mem_if.DatoSalida = salida_q;
  assign mem_if.Listo      = listo_q;
  assign mem_if.Ocupado    = ocupado_q;
  assign mem_if.Error      = error_q;
endmodule

// File: tb/tb_respondedor_memoria.sv
// Directed bench for respondedor_memoria: three instances (2 waits, 0 waits, 200 words).
module tb_respondedor_memoria;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int N = 3;
`ifdef RESPONDEDOR_ERROR_RANGO_EN
  localparam bit RANGO = 1'b1;
`else
  localparam bit RANGO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  respondedor_memoria_if #(.DW(DW), .AW(AW)) bus [N] ();

  respondedor_memoria #(.DW(DW), .AW(AW), .PALABRAS(256), .ESPERAS(2)) u0 (
    .Reloj(clk), .Reiniciar(rst_n), .mem_if(bus[0]));
  respondedor_memoria #(.DW(DW), .AW(AW), .PALABRAS(256), .ESPERAS(0)) u1 (
    .Reloj(clk), .Reiniciar(rst_n), .mem_if(bus[1]));
  respondedor_memoria #(.DW(DW), .AW(AW), .PALABRAS(200), .ESPERAS(2)) u2 (
    .Reloj(clk), .Reiniciar(rst_n), .mem_if(bus[2]));

  logic          sol  [N];
  logic          esc  [N];
  logic [AW-1:0] dir  [N];
  logic [DW-1:0] din  [N];
  logic [DW-1:0] dout [N];
  logic          lst  [N];
  logic          ocu  [N];
  logic          errf [N];

  for (genvar g = 0; g < N; g++) begin : g_con
    assign bus[g].Solicitud   = sol[g];
    assign bus[g].Escribir    = esc[g];
    assign bus[g].Direccion   = dir[g];
    assign bus[g].DatoEntrada = din[g];
    assign dout[g] = bus[g].DatoSalida;
    assign lst[g]  = bus[g].Listo;
    assign ocu[g]  = bus[g].Ocupado;
    assign errf[g] = bus[g].Error;
  end

  int unsigned   pal [N] = '{256, 256, 200};
  int            esp [N] = '{2, 0, 2};
  logic [DW-1:0] mdl [N][256];
  logic [DW-1:0] ult [N];
  logic [DW-1:0] sb_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esperado);
    n_cmp++;
    assert (obs === esperado) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, esperado);
    end
  endtask

  // One complete four-phase access; called and returns on a falling edge
  task automatic acceso(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int hold);
    int n;
    logic fuera;
    logic [DW-1:0] exp_d;
    fuera = RANGO && (32'(a) >= pal[i]);
    if (!we) begin
      if (fuera) sb_q.push_back(ult[i]);
      else       sb_q.push_back(mdl[i][32'(a) % pal[i]]);
    end
    sol[i] = 1'b1; esc[i] = we; dir[i] = a; din[i] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!lst[i]) chk("ocupado_espera", 32'(ocu[i]), 1);
    end while (!lst[i] && n < 20);
    chk("latencia", n, esp[i] + 2);
    chk("error_listo", 32'(errf[i]), 32'(fuera));
    chk("ocupado_listo", 32'(ocu[i]), 1);
    if (!we) begin
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      chk("dato_lectura", 32'(dout[i]), 32'(exp_d));
      ult[i] = exp_d;
    end else begin
      chk("dato_tras_escritura", 32'(dout[i]), 32'(ult[i]));
      if (!fuera) mdl[i][32'(a) % pal[i]] = d;
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("listo_mantenido", 32'(lst[i]), 1);
    end
    sol[i] = 1'b0;
    @(negedge clk);
    chk("listo_baja", 32'(lst[i]), 0);
    chk("ocupado_baja", 32'(ocu[i]), 0);
    chk("error_baja", 32'(errf[i]), 0);
  endtask

  task automatic abortar(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sol[i] = 1'b1; esc[i] = 1'b1; dir[i] = a; din[i] = d;
    @(negedge clk);
    chk("ocupado_aborto_espera", 32'(ocu[i]), 1);
    sol[i] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("listo_aborto", 32'(lst[i]), 0);
    end
    chk("ocupado_aborto", 32'(ocu[i]), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      sol[i] = 1'b0; esc[i] = 1'b0; dir[i] = '0; din[i] = '0; ult[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("reset_listo", 32'(lst[i]), 0);
      chk("reset_ocupado", 32'(ocu[i]), 0);
      chk("reset_error", 32'(errf[i]), 0);
      chk("reset_dato", 32'(dout[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read with two wait states
    acceso(0, 1'b1, 8'h10, 16'hBEEF, 0);
    acceso(0, 1'b0, 8'h10, 16'h0000, 0);

    // Long hold in LISTO
    acceso(0, 1'b1, 8'h11, 16'h0F0F, 6);
    acceso(0, 1'b0, 8'h11, 16'h0000, 6);

    // Abort during wait leaves old contents
    acceso(0, 1'b1, 8'h20, 16'hAAAA, 0);
    abortar(0, 8'h20, 16'h1234);
    acceso(0, 1'b0, 8'h20, 16'h0000, 0);

    // Zero wait states, back-to-back
    acceso(1, 1'b1, 8'h05, 16'hCAFE, 0);
    acceso(1, 1'b0, 8'h05, 16'h0000, 0);
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(0, 255));
      d = DW'($urandom);
      acceso(1, 1'b1, a, d, 0);
      acceso(1, 1'b0, a, 16'h0000, 0);
    end

    // Out-of-range handling on a 200-word store
    acceso(2, 1'b1, 8'h00, 16'h1111, 0);
    acceso(2, 1'b0, 8'h00, 16'h0000, 0);
    acceso(2, 1'b1, 8'hC8, 16'h5555, 0);
    acceso(2, 1'b0, 8'h00, 16'h0000, 0);
    acceso(2, 1'b0, 8'hC8, 16'h0000, 0);

    // Reset in the middle of a write wait
    sol[0] = 1'b1; esc[0] = 1'b1; dir[0] = 8'h10; din[0] = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_async_listo", 32'(lst[i]), 0);
      chk("rst_async_ocupado", 32'(ocu[i]), 0);
      chk("rst_async_error", 32'(errf[i]), 0);
      chk("rst_async_dato", 32'(dout[i]), 0);
      ult[i] = '0;
    end
    sol[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acceso(0, 1'b0, 8'h10, 16'h0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
